// File: rtl/sky130_ef_ip__rc_osc_500k_pkg.sv
// Shared types and width helpers for the 500 kHz RC oscillator monitor.
package sky130_ef_ip__rc_osc_500k_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_READY   = 3'd2,
    ST_MEASURE = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Width of a down-counter that is loaded with (cycles - 1) and runs to zero.
  function automatic int cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sky130_ef_ip__rc_osc_500k_sync.sv
// Two-flop synchronizer for the oscillator output plus a rising-edge detector.
module sky130_ef_ip__rc_osc_500k_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic rise
);

  // sh_q[0..1] synchronize, sh_q[2] holds the previous synchronized value
  logic [2:0] sh_q;

  // shift the asynchronous oscillator level through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= 3'b000;
    end else begin
      sh_q <= {sh_q[1:0], osc_in};
    end
  end

  assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/sky130_ef_ip__rc_osc_500k_mon.sv
// Monitor/controller for the 500 kHz RC oscillator: enable sequencing,
// warm-up delay, gated edge counting and stall detection.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_OFF     | oscillator disabled, waiting for en
// ST_WARMUP  | oscillator enabled, start-up timer running, edges ignored
// ST_READY   | warmed up and idle, start accepted, stall timer running
// ST_MEASURE | gate window open, counting rises, stall timer running
// ST_FAULT   | no rise seen for STALL_CYCLES, held until en drops
module sky130_ef_ip__rc_osc_500k_mon
  import sky130_ef_ip__rc_osc_500k_pkg::*;
#(
  parameter int GATE_CYCLES    = 1000,
  parameter int STARTUP_CYCLES = 256,
  parameter int STALL_CYCLES   = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_ena,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             fail
);

  localparam int WARM_W  = cnt_w(STARTUP_CYCLES);
  localparam int WIN_W   = cnt_w(GATE_CYCLES);
  localparam int STALL_W = cnt_w(STALL_CYCLES);

  localparam logic [WARM_W-1:0]  WARM_LOAD  = WARM_W'(STARTUP_CYCLES - 1);
  localparam logic [WIN_W-1:0]   WIN_LOAD   = WIN_W'(GATE_CYCLES - 1);
  // Stall timer counts the cycles still to go before fail is shown.
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  state_t state_q, state_d;

  logic               rise;
  logic [WARM_W-1:0]  warm_q;
  logic [WIN_W-1:0]   win_q;
  logic [STALL_W-1:0] stall_q;
  logic [CNT_W-1:0]   edges_q, edges_nxt;
  logic               stall_hit;
  logic               meas_start, meas_end, ready_entry;

  logic               osc_ena_q, ready_q, busy_q, fail_q, done_q;
  logic [CNT_W-1:0]   count_q;

  sky130_ef_ip__rc_osc_500k_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .rise   (rise)
  );

  // A rise in the same cycle the timer expires keeps the oscillator alive.
  assign stall_hit   = (stall_q == STALL_W'(1)) && !rise;
  assign edges_nxt   = (rise && (edges_q != CNT_MAX)) ? edges_q + CNT_W'(1) : edges_q;
  assign meas_start  = (state_q == ST_READY) && (state_d == ST_MEASURE);
  assign meas_end    = (state_q == ST_MEASURE) && (state_d == ST_READY);
  assign ready_entry = (state_q != ST_READY) && (state_d == ST_READY);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode; en low overrides everything, stall beats start/window end
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:     state_d = ST_WARMUP;
        ST_WARMUP:  if (warm_q == '0) state_d = ST_READY;
        ST_READY: begin
          if (stall_hit)  state_d = ST_FAULT;
          else if (start) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (stall_hit)          state_d = ST_FAULT;
          else if (win_q == '0)   state_d = ST_READY;
        end
        ST_FAULT:   state_d = ST_FAULT;
        default:    state_d = ST_OFF;
      endcase
    end
  end

  // warm-up, window, edge and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= '0;
      win_q   <= '0;
      edges_q <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == ST_OFF && state_d == ST_WARMUP) begin
        warm_q <= WARM_LOAD;
      end else if (state_q == ST_WARMUP && warm_q != '0) begin
        warm_q <= warm_q - WARM_W'(1);
      end

      if (meas_start) begin
        win_q   <= WIN_LOAD;
        edges_q <= '0;
      end else if (state_q == ST_MEASURE) begin
        if (win_q != '0) win_q <= win_q - WIN_W'(1);
        edges_q <= edges_nxt;
      end

      if (ready_entry || rise) begin
        stall_q <= STALL_LOAD;
      end else if ((state_q == ST_READY || state_q == ST_MEASURE) && stall_q != '0) begin
        stall_q <= stall_q - STALL_W'(1);
      end
    end
  end

  // registered status outputs, result latch and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_ena_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      osc_ena_q <= (state_d != ST_OFF);
      ready_q   <= (state_d == ST_READY);
      busy_q    <= (state_d == ST_MEASURE);
      fail_q    <= (state_d == ST_FAULT);
      done_q    <= meas_end;
      if (meas_end) count_q <= edges_nxt;
    end
  end

  assign osc_ena = osc_ena_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign fail    = fail_q;
  assign done    = done_q;
  assign count   = count_q;

endmodule

// File: doc/sky130_ef_ip__rc_osc_500k_mon.md
# sky130_ef_ip__rc_osc_500k_mon

Digital monitor and controller for the 500 kHz RC oscillator macro, sitting in the core digital domain on the receiving end of the oscillator's `dout`. It drives the oscillator `ena` and waits out a start-up delay. It then counts synchronized oscillator rising edges over a gate window of system clocks and reports the count. If the oscillator stalls, it flags a latched failure.

## Interface
Parameters:
- `GATE_CYCLES`, 1000: system-clock cycles per measurement window.
- `STARTUP_CYCLES`, 256: cycles between `osc_ena` rising and `ready`.
- `STALL_CYCLES`, 64: cycles without an oscillator rising edge that declare a failure.
- `CNT_W`, 16: width of the edge count.

Ports:
- `clk`, in, 1: system clock; must be at least 8× the oscillator frequency.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en`, in, 1: level request to run the oscillator.
- `start`, in, 1: single-cycle measurement request.
- `osc_in`, in, 1: oscillator `dout`, asynchronous to `clk`.
- `osc_ena`, out, 1: registered enable to the oscillator `ena`.
- `ready`, out, 1: oscillator is warmed up and idle; `start` is accepted.
- `busy`, out, 1: measurement in progress.
- `done`, out, 1: one-cycle pulse when `count` updates.
- `count`, out, `CNT_W`: edges counted in the last completed window; saturating.
- `fail`, out, 1: oscillator stall detected; latched.

## Operation
Reset values: all outputs 0; state OFF; all counters 0.

`osc_in` passes through a 2-flop synchronizer. A third flop detects edges, producing a one-cycle `rise` pulse on each 0→1 transition.

State machine:
- OFF: `osc_ena`=0. When `en`=1, go to WARMUP; `osc_ena` goes to 1 the same cycle the state changes.
- WARMUP: a counter runs `STARTUP_CYCLES` cycles, then the block enters READY. Edges are ignored in this state.
- READY: `ready`=1.
  - On `start`=1: enter MEASURE and clear both the edge counter and the window counter.
- MEASURE: `busy`=1.
  - Each `rise` increments the edge counter, saturating at 2^`CNT_W`−1.
  - After `GATE_CYCLES` cycles in MEASURE, the block returns to READY and loads the edge counter into `count`.
  - `done`=1 in the first READY cycle.
- FAULT: `fail`=1. Entered from READY or MEASURE when the stall counter reaches `STALL_CYCLES`.
  - Any measurement in progress is aborted: no `done`, and `count` is unchanged.
  - The block stays in FAULT until `en`=0.

Stall counter:
- Clears on entry to READY and on every `rise`.
- Increments each cycle in READY and MEASURE.

Boundary rules:
- `en`=0 in any state: go to OFF next cycle; `osc_ena`, `ready`, `busy` and `fail` drop. Any measurement in progress is aborted with no `done`; `count` is retained.
- `start` outside READY is ignored and not queued.
- A `rise` in the final window cycle is counted.
- A `rise` in the same cycle the stall threshold is reached wins: no fault is raised.
- `count` holds its value until the next `done`, or until reset.
- `rst_n` low mid-operation: all outputs return to their reset values immediately.

## Timing
- Oscillator edge to `rise`: 2–3 `clk` cycles.
- `start` sampled in READY at cycle N:
  - `busy`=1 for cycles N+1 through N+`GATE_CYCLES`.
  - `done`=1 and the new `count` are visible at cycle N+`GATE_CYCLES`+1, where `ready`=1 again.
- `en` rising sampled at cycle N: `osc_ena`=1 from N+1; `ready`=1 from N+1+`STARTUP_CYCLES`.
- Fault: `fail`=1 exactly `STALL_CYCLES` cycles after the last `rise`.
- Expected window count = f_osc × `GATE_CYCLES` / f_clk, ±1 edge.

## Structure
- Shared package: the state enum (OFF, WARMUP, READY, MEASURE, FAULT) and counter-width helper constants, `$clog2` of each cycle parameter.
- Sub-module `sky130_ef_ip__rc_osc_500k_sync`: the 2-flop synchronizer plus rising-edge detector, output `rise`; reset value 0.
- The top level holds the state machine and the warm-up, window, edge and stall counters.

## Test plan
Unless stated otherwise: `clk` at 10 MHz, oscillator model at 500 kHz, default parameters.
- Reset then `en`=1 → `osc_ena`=1 next cycle; `ready`=1 exactly 257 cycles after `en` was sampled.
- `start` in READY → `busy` high for 1000 cycles; `done` pulses once; `count` = 50 ±1.
- `CNT_W`=4 with a 2 MHz oscillator → `count`=15 (saturated); `done` still pulses after 1000 cycles.
- Hold `osc_in` low after READY → `fail`=1 at 64 cycles after the last edge, with no `done`. Then `en`=0 → `fail`=0 next cycle and the state returns to OFF.
- `en` dropped 300 cycles into MEASURE → `osc_ena`, `busy` = 0 next cycle; no `done`; `count` keeps its previous value (50).
- `start` pulses during WARMUP and during MEASURE are ignored: exactly one `done` per accepted `start`, and `done` timing is unchanged.
